// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit 7-segment display among up to four requesters,
// with a minimum dwell before preemption. Define SEG_ARB_SRC_TAG_EN to show the owner index on the leftmost digit.
module seg_display_arbiter #(
    parameter int N_SRC       = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_SRC-1:0]     REQ,
    input  logic [16*N_SRC-1:0]  VAL,
    output logic [N_SRC-1:0]     GNT,
    output logic                 LATCH,
    output logic [15:0]          NUM,
    output logic [1:0]           SRC,
    output logic                 ACTIVE
);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   gnt_q, gnt_d;
    logic               latch_q, latch_d;
    logic [15:0]        num_q, num_d;
    logic [1:0]         src_q, src_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Requests and values padded to four slots so a 2-bit index is always in range.
    logic [3:0]         req_pad;
    logic [15:0]        val_arr [0:3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < N_SRC) begin : g_real
                assign req_pad[gi] = REQ[gi];
                assign val_arr[gi] = VAL[16*gi +: 16];
            end else begin : g_absent
                assign req_pad[gi] = 1'b0;
                assign val_arr[gi] = 16'h0000;
            end
        end
    endgenerate

    logic       sel_found;
    logic [1:0] sel_idx;
    logic [1:0] scan_idx;
    logic       owner_req;
    logic       other_req;
    logic       do_grant;
    logic [1:0] disp_idx;
    logic [15:0] disp_num;

    // Rotating priority scan starting at the round-robin pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = 2'((int'(ptr_q) + k) % N_SRC);
            if (!sel_found && req_pad[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        owner_req = req_pad[src_q];
        other_req = |(req_pad & ~(4'b0001 << src_q));

        do_grant = 1'b0;
        if (state_q == S_IDLE || !owner_req) begin
            do_grant = sel_found;
        end else if (cnt_q == CNT_MAX && other_req) begin
            // ptr already sits at owner+1, so the scan reaches the owner last.
            do_grant = 1'b1;
        end

        disp_idx = do_grant ? sel_idx : src_q;
`ifdef SEG_ARB_SRC_TAG_EN
        disp_num = {2'b00, disp_idx, val_arr[disp_idx][11:0]};
`else
        disp_num = val_arr[disp_idx];
`endif

        state_d = state_q;
        gnt_d   = gnt_q;
        latch_d = 1'b0;
        num_d   = num_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        if (do_grant) begin
            state_d = S_SHOW;
            gnt_d   = N_SRC'(4'b0001 << sel_idx);
            latch_d = 1'b1;
            num_d   = disp_num;
            src_d   = sel_idx;
            ptr_d   = 2'((int'(sel_idx) + 1) % N_SRC);
            cnt_d   = '0;
        end else if (state_q == S_SHOW && owner_req) begin
            num_d = disp_num;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // Nobody wants the display: release it but leave the last value frozen.
            state_d = S_IDLE;
            gnt_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            latch_q <= 1'b0;
            num_q   <= 16'h0000;
            src_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            latch_q <= latch_d;
            num_q   <= num_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GNT    = gnt_q;
    assign LATCH  = latch_q;
    assign NUM    = num_q;
    assign SRC    = src_q;
    assign ACTIVE = (state_q == S_SHOW);

endmodule
